// File: rtl/rc5_pkg.sv
// Shared constants, FSM state type and S-table initial values for the RC5-16 key schedule.
package rc5_pkg;

    localparam int W          = 16;
    localparam int C          = 8;
    localparam int MAX_ROUNDS = 16;
    localparam int T_MAX      = 2 * (MAX_ROUNDS + 1);
    localparam int KEY_W      = W * C;
    localparam int ADDR_W     = 6;
    localparam int ROUND_W    = 5;

    localparam logic [W-1:0] P16 = 16'hB7E1;
    localparam logic [W-1:0] Q16 = 16'h9E37;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_MIX,
        ST_DONE
    } ks_state_t;

    // Magic-constant progression P16 + idx*Q16, truncated to 16 bits.
    function automatic logic [W-1:0] s_init(input logic [ADDR_W-1:0] idx);
        return P16 + Q16 * W'(idx);
    endfunction

endpackage

// File: rtl/rc5_key_schedule_if.sv
// Control, key input and subkey read port of the RC5-16 key schedule.
interface rc5_key_schedule_if;
    import rc5_pkg::*;

    logic                start;
    logic [KEY_W-1:0]    key;
    logic [ROUND_W-1:0]  num_rounds;
    logic                busy;
    logic                done;
    logic                valid;
    logic [ADDR_W-1:0]   sk_addr;
    logic [W-1:0]        sk_data;

    modport master (
        output start, key, num_rounds, sk_addr,
        input  busy, done, valid, sk_data
    );

    modport slave (
        input  start, key, num_rounds, sk_addr,
        output busy, done, valid, sk_data
    );

endinterface

// File: rtl/rotl.sv
// 16-bit (parameterisable) rotate-left by a variable amount.
module rotl #(
    parameter int W = 16
) (
    input  logic [W-1:0]         data_i,
    input  logic [$clog2(W)-1:0] n_i,
    output logic [W-1:0]         data_o
);

    logic [2*W-1:0] doubled;

    always_comb begin
        doubled = {data_i, data_i} << n_i;
        data_o  = doubled[2*W-1:W];
    end

endmodule

// File: rtl/rc5_key_schedule.sv
// RC5-16 key expansion (b=16, c=8): one mixing step per cycle, combinational subkey read port.
// Define RC5_KS_FAST_INIT_EN to load the whole S table in a single INIT cycle.
module rc5_key_schedule
    import rc5_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rc5_key_schedule_if.slave bus
);

    ks_state_t state, state_nx;

    logic [W-1:0]       s_mem [T_MAX];
    logic [W-1:0]       l_mem [C];
    logic [W-1:0]       a_reg, b_reg;
    logic [ADDR_W-1:0]  i_cnt, t_reg;
    logic [2:0]         j_cnt;
    logic [6:0]         k_cnt, n_reg;
    logic               valid_reg;

    logic [ROUND_W-1:0] r_clamp;
    logic [ADDR_W-1:0]  t_calc;
    logic [6:0]         n_calc;
    logic [W-1:0]       a_sum, a_new, ab_sum, b_sum, b_new;
    logic               last_i, last_k;

    always_comb begin
        r_clamp = (bus.num_rounds > ROUND_W'(MAX_ROUNDS)) ? ROUND_W'(MAX_ROUNDS) : bus.num_rounds;
        t_calc  = {r_clamp, 1'b0} + 6'd2;
        n_calc  = (t_calc > 6'd8) ? 7'(t_calc) * 7'd3 : 7'd24;
        last_i  = (i_cnt == t_reg - 6'd1);
        last_k  = (k_cnt == n_reg - 7'd1);
        a_sum   = s_mem[i_cnt] + a_reg + b_reg;
        ab_sum  = a_new + b_reg;
        b_sum   = l_mem[j_cnt] + ab_sum;
    end

    rotl #(.W(W)) u_rotl_a (.data_i(a_sum), .n_i(4'd3),        .data_o(a_new));
    rotl #(.W(W)) u_rotl_b (.data_i(b_sum), .n_i(ab_sum[3:0]), .data_o(b_new));

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_INIT;
`ifdef RC5_KS_FAST_INIT_EN
            ST_INIT: state_nx = ST_MIX;
`else
            ST_INIT: if (last_i) state_nx = ST_MIX;
`endif
            ST_MIX:  if (last_k) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.valid   = valid_reg;
    assign bus.sk_data = (valid_reg && (bus.sk_addr < t_reg)) ? s_mem[bus.sk_addr] : '0;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            valid_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            t_reg     <= '0;
            n_reg     <= '0;
            // NOTE: the S and L arrays are cleared here because reset must leave no key material behind.
            for (int q = 0; q < T_MAX; q++) s_mem[q] <= '0;
            for (int q = 0; q < C; q++)     l_mem[q] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (bus.start) begin
                    valid_reg <= 1'b0;
                    t_reg     <= t_calc;
                    n_reg     <= n_calc;
                    a_reg     <= '0;
                    b_reg     <= '0;
                    i_cnt     <= '0;
                    j_cnt     <= '0;
                    k_cnt     <= '0;
                    for (int q = 0; q < C; q++) l_mem[q] <= bus.key[W*q +: W];
                end
                ST_INIT: begin
`ifdef RC5_KS_FAST_INIT_EN
                    for (int q = 0; q < T_MAX; q++) s_mem[q] <= s_init(ADDR_W'(q));
                    i_cnt <= '0;
`else
                    s_mem[i_cnt] <= s_init(i_cnt);
                    i_cnt        <= last_i ? '0 : i_cnt + 6'd1;
`endif
                end
                ST_MIX: begin
                    s_mem[i_cnt] <= a_new;
                    l_mem[j_cnt] <= b_new;
                    a_reg        <= a_new;
                    b_reg        <= b_new;
                    i_cnt        <= last_i ? '0 : i_cnt + 6'd1;
                    j_cnt        <= j_cnt + 3'd1;
                    k_cnt        <= k_cnt + 7'd1;
                end
                ST_DONE: valid_reg <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_key_schedule.sv
// Self-checking bench for rc5_key_schedule: table-driven schedule runs against a reference model plus reset/protocol sequences.
module tb_rc5_key_schedule;

`ifdef RC5_KS_FAST_INIT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef logic [15:0] tab_t [34];

    typedef struct {
        logic [127:0] key;
        logic [4:0]   rounds;
        int           glitch;      // 0 none, -1 during DONE, >0 that cycle
        int           done_seq;
        int           done_fast;
        int           t;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rc5_key_schedule_if ks_if ();
    rc5_key_schedule dut (.clk(clk), .rst(rst), .bus(ks_if));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rol16(input logic [15:0] x, input logic [3:0] n);
        return (x << n) | (x >> (5'd16 - {1'b0, n}));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] x, input logic [3:0] n);
        return (x >> n) | (x << (5'd16 - {1'b0, n}));
    endfunction

    // Reference RC5-16 key expansion, b=16 bytes.
    function automatic tab_t golden(input logic [127:0] key, input logic [4:0] r);
        tab_t        s;
        logic [15:0] l [8];
        logic [15:0] a, b;
        int          rr, t, n, i, j;
        rr = (r > 5'd16) ? 16 : int'(r);
        t  = 2 * (rr + 1);
        n  = 3 * ((t > 8) ? t : 8);
        for (int q = 0; q < 34; q++) s[q] = 16'h0000;
        for (int q = 0; q < t; q++)  s[q] = 16'hB7E1 + 16'(q) * 16'h9E37;
        for (int q = 0; q < 8; q++)  l[q] = key[16*q +: 16];
        a = 0; b = 0; i = 0; j = 0;
        for (int k = 0; k < n; k++) begin
            a    = rol16(s[i] + a + b, 4'd3);
            s[i] = a;
            b    = rol16(l[j] + a + b, 4'(a + b));
            l[j] = b;
            i    = (i + 1) % t;
            j    = (j + 1) % 8;
        end
        return s;
    endfunction

    function automatic logic [31:0] enc(input logic [31:0] pt, input tab_t s, input int r);
        logic [15:0] a, b;
        a = pt[15:0] + s[0];
        b = pt[31:16] + s[1];
        for (int i = 1; i <= r; i++) begin
            a = rol16(a ^ b, b[3:0]) + s[2*i];
            b = rol16(b ^ a, a[3:0]) + s[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic logic [31:0] dec(input logic [31:0] ct, input tab_t s, input int r);
        logic [15:0] a, b;
        a = ct[15:0];
        b = ct[31:16];
        for (int i = r; i >= 1; i--) begin
            b = ror16(b - s[2*i+1], a[3:0]) ^ a;
            a = ror16(a - s[2*i], b[3:0]) ^ b;
        end
        return {b - s[1], a - s[0]};
    endfunction

    // Launch one expansion; the key and round inputs are scrambled once start has been taken.
    task automatic run(input logic [127:0] key, input logic [4:0] r, input int glitch, output int done_cyc);
        @(negedge clk);
        ks_if.start      = 1'b1;
        ks_if.key        = key;
        ks_if.num_rounds = r;
        done_cyc = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_after_start", 32'(ks_if.busy), 32'd1);
                check("valid_drop_on_start", 32'(ks_if.valid), 32'd0);
            end
            ks_if.key        = {$urandom, $urandom, $urandom, $urandom};
            ks_if.num_rounds = 5'($urandom);
            ks_if.start      = (c == glitch) || (glitch < 0 && ks_if.done);
            if (ks_if.done) begin
                done_cyc = c;
                break;
            end
        end
        @(negedge clk);
        ks_if.start = 1'b0;
        check("valid_after_done", 32'(ks_if.valid), 32'd1);
        check("idle_after_done", 32'(ks_if.busy), 32'd0);
    endtask

    task automatic check_table(input logic [127:0] key, input logic [4:0] r, input int t);
        tab_t exp_s;
        exp_s = golden(key, r);
        for (int a = 0; a < 64; a++) begin
            ks_if.sk_addr = 6'(a);
            #1;
            check($sformatf("S[%0d]", a), 32'(ks_if.sk_data), (a < t) ? 32'(exp_s[a]) : 32'd0);
        end
    endtask

    vec_t vecs [7];
    int   dcyc;

    initial begin
        vecs[0] = '{128'h0, 5'd16, 0, 137, 104, 34};
        vecs[1] = '{128'h0F0E0D0C0B0A09080706050403020100, 5'd12, 0, 105, 80, 26};
        vecs[2] = '{128'h0123456789ABCDEFFEDCBA9876543210, 5'd0, 5, 27, 26, 2};
        vecs[3] = '{128'h0123456789ABCDEFFEDCBA9876543210, 5'd31, -1, 137, 104, 34};
        vecs[4] = '{128'h0123456789ABCDEFFEDCBA9876543210, 5'd16, 20, 137, 104, 34};
        vecs[5] = '{128'hDEADBEEFCAFEF00D5555AAAA00FF1234, 5'd2, 0, 31, 26, 6};
        vecs[6] = '{128'hDEADBEEFCAFEF00D5555AAAA00FF1234, 5'd4, 0, 41, 32, 10};

        rst = 1'b1;
        ks_if.start      = 1'b0;
        ks_if.key        = '0;
        ks_if.num_rounds = '0;
        ks_if.sk_addr    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",  32'(ks_if.busy),    32'd0);
        check("reset_done",  32'(ks_if.done),    32'd0);
        check("reset_valid", 32'(ks_if.valid),   32'd0);
        check("reset_data",  32'(ks_if.sk_data), 32'd0);

        for (int v = 0; v < 7; v++) begin
            run(vecs[v].key, vecs[v].rounds, vecs[v].glitch, dcyc);
            check($sformatf("done_cycle_v%0d", v), 32'(dcyc),
                  32'(FAST ? vecs[v].done_fast : vecs[v].done_seq));
            check_table(vecs[v].key, vecs[v].rounds, vecs[v].t);
        end

        // Reset while the table is valid and idle.
        @(negedge clk);
        ks_if.sk_addr = 6'd3;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_idle_valid", 32'(ks_if.valid),   32'd0);
        check("rst_idle_data",  32'(ks_if.sk_data), 32'd0);

        // Reset in the middle of MIX, then a clean run.
        @(negedge clk);
        ks_if.start      = 1'b1;
        ks_if.key        = 128'hFFFF0000FFFF0000123456789ABCDEF0;
        ks_if.num_rounds = 5'd16;
        @(negedge clk);
        ks_if.start = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_mix_busy", 32'(ks_if.busy), 32'd1);
        ks_if.sk_addr = 6'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mix_busy",  32'(ks_if.busy),    32'd0);
        check("rst_mix_done",  32'(ks_if.done),    32'd0);
        check("rst_mix_valid", 32'(ks_if.valid),   32'd0);
        check("rst_mix_data",  32'(ks_if.sk_data), 32'd0);
        run(128'hFFFF0000FFFF0000123456789ABCDEF0, 5'd16, 0, dcyc);
        check("done_cycle_after_rst", 32'(dcyc), FAST ? 32'd104 : 32'd137);
        check_table(128'hFFFF0000FFFF0000123456789ABCDEF0, 5'd16, 34);

        // Cipher round trip using the table served by the read port.
        begin
            tab_t        dut_s, ref_s;
            logic [31:0] ct;
            ref_s = golden(128'hFFFF0000FFFF0000123456789ABCDEF0, 5'd16);
            for (int a = 0; a < 34; a++) begin
                ks_if.sk_addr = 6'(a);
                #1;
                dut_s[a] = ks_if.sk_data;
            end
            ct = enc(32'h1234_5678, dut_s, 16);
            check("cipher_text", ct, enc(32'h1234_5678, ref_s, 16));
            check("round_trip", dec(ct, dut_s, 16), 32'h1234_5678);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
